// File: rtl/rv_lsu.sv
// Load/store unit stage for a small RV32 pipeline.
// Captures the execute-stage result, issues one data-bus access per memory
// instruction, and holds the pipeline (o_stall) until the bus acknowledges.
// Non-memory instructions pass through in a single cycle.
//
// Bus handshake: o_dbus_req is held high, together with stable
// o_dbus_we/o_dbus_addr/o_dbus_sel/o_dbus_wdata, from the cycle after the
// instruction is captured until the cycle in which i_dbus_ack=1. The transfer
// completes on that rising edge; i_dbus_err and i_dbus_rdata are only looked
// at while i_dbus_ack=1. o_dbus_req drops in the following cycle.
module rv_lsu (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_rs2_val,
  input  logic [4:0]  i_rd,
  input  logic [31:2] i_pc_p4,
  input  logic [1:0]  i_res_src,
  input  logic [2:0]  i_funct3,
  input  logic        i_reg_write,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  output logic        o_stall,
  output logic [4:0]  o_rd,
  output logic [31:2] o_pc_p4,
  output logic [1:0]  o_res_src,
  output logic [31:0] o_alu_result,
  output logic        o_reg_write,
  output logic [31:0] o_load_data,
  output logic        o_misaligned,
  output logic        o_fault,
  output logic        o_dbus_req,
  output logic        o_dbus_we,
  output logic [31:2] o_dbus_addr,
  output logic [3:0]  o_dbus_sel,
  output logic [31:0] o_dbus_wdata,
  input  logic        i_dbus_ack,
  input  logic        i_dbus_err,
  input  logic [31:0] i_dbus_rdata
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  state_e      state_q, state_d;

  // Stage registers (pipeline payload of the instruction sitting here).
  logic [4:0]  rd_q, rd_d;
  logic [31:2] pc_p4_q, pc_p4_d;
  logic [1:0]  res_src_q, res_src_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        fault_q, fault_d;

  // Request registers: drive the bus for the whole transfer, independent of
  // the stage registers so a flush cannot disturb an in-flight access.
  logic        req_we_q, req_we_d;
  logic [31:2] req_addr_q, req_addr_d;
  logic [3:0]  req_sel_q, req_sel_d;
  logic [31:0] req_wdata_q, req_wdata_d;

  // Raw read data returned by the last completed load.
  logic [31:0] r_rdata_q, r_rdata_d;

  logic        stalled;
  logic        mem_live;
  logic        new_mem;
  logic        new_aligned;
  logic [3:0]  new_sel;
  logic [31:0] new_wdata;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Natural alignment for the access size encoded in funct3[1:0].
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = (addr[0] == 1'b0);
      default: ok = (addr == 2'b00);
    endcase
    return ok;
  endfunction

  assign stalled     = (state_q == S_REQ);
  assign mem_live    = mem_read_q | mem_write_q;
  assign new_mem     = i_mem_read | i_mem_write;
  assign new_aligned = is_aligned(i_funct3[1:0], i_alu_result[1:0]);

  // Byte lanes and write data of the incoming instruction's bus access.
  always_comb begin
    new_sel   = 4'b1111;
    new_wdata = 32'h0;
    if (i_mem_write) begin
      case (i_funct3[1:0])
        2'b00: begin
          new_sel   = 4'b0001 << i_alu_result[1:0];
          new_wdata = {4{i_rs2_val[7:0]}};
        end
        2'b01: begin
          new_sel   = i_alu_result[1] ? 4'b1100 : 4'b0011;
          new_wdata = {2{i_rs2_val[15:0]}};
        end
        default: begin
          new_sel   = 4'b1111;
          new_wdata = i_rs2_val;
        end
      endcase
    end
  end

  // Next-state: stage load/flush, FSM, request capture and read-data latch.
  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    pc_p4_d      = pc_p4_q;
    res_src_d    = res_src_q;
    alu_result_d = alu_result_q;
    funct3_d     = funct3_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    fault_d      = fault_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_sel_d    = req_sel_q;
    req_wdata_d  = req_wdata_q;
    r_rdata_d    = r_rdata_q;

    // Flush wins over load and also applies while a transfer is pending.
    if (i_flush) begin
      rd_d         = 5'd0;
      pc_p4_d      = 30'd0;
      res_src_d    = 2'd0;
      alu_result_d = 32'h0;
      funct3_d     = 3'd0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      fault_d      = 1'b0;
    end else if (!stalled) begin
      rd_d         = i_rd;
      pc_p4_d      = i_pc_p4;
      res_src_d    = i_res_src;
      alu_result_d = i_alu_result;
      funct3_d     = i_funct3;
      reg_write_d  = i_reg_write;
      mem_read_d   = i_mem_read;
      mem_write_d  = i_mem_write;
      fault_d      = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!i_flush && new_mem && new_aligned) begin
          state_d     = S_REQ;
          req_we_d    = i_mem_write;
          req_addr_d  = i_alu_result[31:2];
          req_sel_d   = new_sel;
          req_wdata_d = new_wdata;
        end
      end
      S_REQ: begin
        if (i_dbus_ack) begin
          state_d = S_IDLE;
          // A flushed access still completes on the bus, but its result
          // (data or error) no longer belongs to anything in the stage.
          if (mem_live && !i_flush) begin
            fault_d = i_dbus_err;
            if (!req_we_q && !i_dbus_err) begin
              r_rdata_d = i_dbus_rdata;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, stage, request and read-data registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      rd_q         <= 5'd0;
      pc_p4_q      <= 30'd0;
      res_src_q    <= 2'd0;
      alu_result_q <= 32'h0;
      funct3_q     <= 3'd0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      fault_q      <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= 30'd0;
      req_sel_q    <= 4'd0;
      req_wdata_q  <= 32'h0;
      r_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      pc_p4_q      <= pc_p4_d;
      res_src_q    <= res_src_d;
      alu_result_q <= alu_result_d;
      funct3_q     <= funct3_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      fault_q      <= fault_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_sel_q    <= req_sel_d;
      req_wdata_q  <= req_wdata_d;
      r_rdata_q    <= r_rdata_d;
    end
  end

  // Load result: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    case (alu_result_q[1:0])
      2'b00:   lane_byte = r_rdata_q[7:0];
      2'b01:   lane_byte = r_rdata_q[15:8];
      2'b10:   lane_byte = r_rdata_q[23:16];
      default: lane_byte = r_rdata_q[31:24];
    endcase
    lane_half = alu_result_q[1] ? r_rdata_q[31:16] : r_rdata_q[15:0];
    case (funct3_q)
      3'b000:  o_load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  o_load_data = {24'h0, lane_byte};
      3'b001:  o_load_data = {{16{lane_half[15]}}, lane_half};
      3'b101:  o_load_data = {16'h0, lane_half};
      default: o_load_data = r_rdata_q;
    endcase
  end

  assign o_stall      = stalled;
  assign o_rd         = rd_q;
  assign o_pc_p4      = pc_p4_q;
  assign o_res_src    = res_src_q;
  assign o_alu_result = alu_result_q;
  assign o_misaligned = mem_live && !is_aligned(funct3_q[1:0], alu_result_q[1:0]);
  assign o_fault      = fault_q;
  assign o_reg_write  = reg_write_q && !o_misaligned && !fault_q;
  assign o_dbus_req   = stalled;
  assign o_dbus_we    = req_we_q;
  assign o_dbus_addr  = req_addr_q;
  assign o_dbus_sel   = req_sel_q;
  assign o_dbus_wdata = req_wdata_q;

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu: per-cycle comparison against expectations
// derived from the access rules, a bus-transfer scoreboard, and literal
// spot checks on the worked examples.
module tb_rv_lsu;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [29:0] pc;
    logic [1:0]  res;
    logic [2:0]  f3;
    logic        rw;
    logic        mr;
    logic        mw;
  } op_t;

  logic        clk;
  logic        i_reset_n;
  logic        i_flush;
  logic [31:0] i_alu_result;
  logic [31:0] i_rs2_val;
  logic [4:0]  i_rd;
  logic [31:2] i_pc_p4;
  logic [1:0]  i_res_src;
  logic [2:0]  i_funct3;
  logic        i_reg_write, i_mem_read, i_mem_write;
  logic        o_stall;
  logic [4:0]  o_rd;
  logic [31:2] o_pc_p4;
  logic [1:0]  o_res_src;
  logic [31:0] o_alu_result;
  logic        o_reg_write;
  logic [31:0] o_load_data;
  logic        o_misaligned, o_fault;
  logic        o_dbus_req, o_dbus_we;
  logic [31:2] o_dbus_addr;
  logic [3:0]  o_dbus_sel;
  logic [31:0] o_dbus_wdata;
  logic        i_dbus_ack, i_dbus_err;
  logic [31:0] i_dbus_rdata;

  rv_lsu dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
    .i_alu_result(i_alu_result), .i_rs2_val(i_rs2_val), .i_rd(i_rd),
    .i_pc_p4(i_pc_p4), .i_res_src(i_res_src), .i_funct3(i_funct3),
    .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .o_stall(o_stall), .o_rd(o_rd), .o_pc_p4(o_pc_p4), .o_res_src(o_res_src),
    .o_alu_result(o_alu_result), .o_reg_write(o_reg_write),
    .o_load_data(o_load_data), .o_misaligned(o_misaligned), .o_fault(o_fault),
    .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we), .o_dbus_addr(o_dbus_addr),
    .o_dbus_sel(o_dbus_sel), .o_dbus_wdata(o_dbus_wdata),
    .i_dbus_ack(i_dbus_ack), .i_dbus_err(i_dbus_err), .i_dbus_rdata(i_dbus_rdata)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Scoreboard of expected bus transfers: {we, sel, addr[31:2], wdata}
  logic [66:0] exp_q[$];

  // Expected per-cycle outputs
  logic        chk_on = 1'b0;
  logic        e_stall = 1'b0;
  logic        e_stage = 1'b0;
  logic [4:0]  e_rd;
  logic [29:0] e_pc;
  logic [1:0]  e_res;
  logic [31:0] e_alu;
  logic        e_rw, e_mis, e_fault;
  logic        e_ld_chk = 1'b0;
  logic [31:0] e_ld;

  // Observations for literal spot checks
  int          req_cnt = 0;
  int          stall_cnt = 0;
  logic [29:0] obs_addr;
  logic [3:0]  obs_sel;
  logic        obs_we;
  logic [31:0] obs_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---- reference rules ----
  function automatic logic f_aligned(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'b00) return 1'b1;
    if (f3[1:0] == 2'b01) return a[0] == 1'b0;
    return a[1:0] == 2'b00;
  endfunction

  function automatic logic [3:0] f_sel(input op_t op);
    if (!op.mw) return 4'hF;
    if (op.f3[1:0] == 2'b00) return 4'b0001 << op.alu[1:0];
    if (op.f3[1:0] == 2'b01) return op.alu[1] ? 4'b1100 : 4'b0011;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wdata(input op_t op);
    if (op.f3[1:0] == 2'b00) return {4{op.rs2[7:0]}};
    if (op.f3[1:0] == 2'b01) return {2{op.rs2[15:0]}};
    return op.rs2;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] s;
    case (f3)
      3'b000: begin s = w >> (8 * a[1:0]);  return (s & 32'hFF)   | (s[7]  ? 32'hFFFFFF00 : 32'h0); end
      3'b100: begin s = w >> (8 * a[1:0]);  return s & 32'hFF; end
      3'b001: begin s = w >> (16 * a[1]);   return (s & 32'hFFFF) | (s[15] ? 32'hFFFF0000 : 32'h0); end
      3'b101: begin s = w >> (16 * a[1]);   return s & 32'hFFFF; end
      default: return w;
    endcase
  endfunction

  function automatic op_t mk(input logic [2:0] f3, input logic mr, input logic mw,
                             input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
    op_t o;
    o.alu = alu; o.rs2 = rs2; o.rd = rd;
    o.pc  = alu[31:2] ^ 30'h0155_AA01;
    o.res = mr ? 2'b01 : 2'b00;
    o.f3  = f3; o.mr = mr; o.mw = mw; o.rw = !mw;
    return o;
  endfunction

  // ---- expectation helpers ----
  task automatic set_stage(input op_t op, input logic rw, input logic mis, input logic flt);
    e_stage = 1'b1; e_rd = op.rd; e_pc = op.pc; e_res = op.res; e_alu = op.alu;
    e_rw = rw; e_mis = mis; e_fault = flt; e_ld_chk = 1'b0;
  endtask

  task automatic clear_stage;
    e_stage = 1'b1; e_rd = '0; e_pc = '0; e_res = '0; e_alu = '0;
    e_rw = 1'b0; e_mis = 1'b0; e_fault = 1'b0; e_ld_chk = 1'b0;
  endtask

  // ---- driver tasks ----
  task automatic drive(input op_t op);
    i_alu_result = op.alu; i_rs2_val = op.rs2; i_rd = op.rd; i_pc_p4 = op.pc;
    i_res_src = op.res; i_funct3 = op.f3; i_reg_write = op.rw;
    i_mem_read = op.mr; i_mem_write = op.mw;
  endtask

  task automatic drive_nop;
    i_alu_result = '0; i_rs2_val = '0; i_rd = '0; i_pc_p4 = '0; i_res_src = '0;
    i_funct3 = '0; i_reg_write = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
  endtask

  task automatic drive_junk;
    i_alu_result = $urandom; i_rs2_val = $urandom; i_rd = 5'($urandom_range(0, 31));
    i_pc_p4 = 30'($urandom); i_res_src = 2'($urandom_range(0, 3));
    i_funct3 = 3'($urandom_range(0, 7)); i_reg_write = 1'($urandom_range(0, 1));
    i_mem_read = 1'($urandom_range(0, 1)); i_mem_write = 1'($urandom_range(0, 1));
  endtask

  // Called at posedge+1 of a cycle in which the stage accepts input.
  // Returns at posedge+1 of the cycle in which the instruction's results show.
  // flush_at: REQ cycle index in which i_flush is pulsed (-1: none).
  task automatic run_op(input op_t op, input int waits, input logic err,
                        input logic [31:0] rdata, input int flush_at);
    logic mem, ok, flushed;
    mem = op.mr | op.mw;
    ok  = f_aligned(op.f3, op.alu);
    drive(op);
    @(posedge clk); #1;
    if (mem && ok) begin
      exp_q.push_back({op.mw, f_sel(op), op.alu[31:2], f_wdata(op)});
      e_stall = 1'b1;
      flushed = 1'b0;
      drive_junk();
      for (int c = 0; c <= waits; c++) begin
        if (flushed) clear_stage(); else set_stage(op, op.rw, 1'b0, 1'b0);
        i_dbus_ack   = (c == waits);
        i_dbus_err   = (c == waits) && err;
        i_dbus_rdata = (c == waits) ? rdata : $urandom;
        i_flush      = (c == flush_at);
        @(posedge clk); #1;
        if (c == flush_at) flushed = 1'b1;
      end
      i_dbus_ack = 1'b0; i_dbus_err = 1'b0; i_flush = 1'b0;
      e_stall = 1'b0;
      if (flushed) clear_stage();
      else begin
        set_stage(op, op.rw && !err, 1'b0, err);
        e_ld_chk = op.mr && !err;
        e_ld     = f_load(op.f3, op.alu, rdata);
      end
    end else begin
      set_stage(op, op.rw && !(mem && !ok), mem && !ok, 1'b0);
    end
    drive_nop();
  endtask

  task automatic idle(input int n);
    drive_nop();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      clear_stage();
    end
  endtask

  task automatic clr_cnt;
    req_cnt = 0; stall_cnt = 0;
  endtask

  // ---- compare process ----
  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall", o_stall, e_stall);
      chk("dbus_req", o_dbus_req, e_stall);
      if (o_stall) stall_cnt++;
      if (o_dbus_req) begin
        req_cnt++;
        obs_addr = o_dbus_addr; obs_sel = o_dbus_sel; obs_we = o_dbus_we; obs_wdata = o_dbus_wdata;
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL sb_unexpected_req: got req with addr %h, expected none", o_dbus_addr);
        end else begin
          chk("bus_we", o_dbus_we, exp_q[0][66]);
          chk("bus_sel", o_dbus_sel, exp_q[0][65:62]);
          chk("bus_addr", o_dbus_addr, exp_q[0][61:32]);
          if (exp_q[0][66]) chk("bus_wdata", o_dbus_wdata, exp_q[0][31:0]);
          if (i_dbus_ack) void'(exp_q.pop_front());
        end
      end
      if (e_stage) begin
        chk("rd", o_rd, e_rd);
        chk("pc_p4", o_pc_p4, e_pc);
        chk("res_src", o_res_src, e_res);
        chk("alu_result", o_alu_result, e_alu);
        chk("reg_write", o_reg_write, e_rw);
        chk("misaligned", o_misaligned, e_mis);
        chk("fault", o_fault, e_fault);
        if (e_ld_chk) chk("load_data", o_load_data, e_ld);
      end
    end
  end

  // ---- stimulus ----
  initial begin
    i_reset_n = 1'b0; i_flush = 1'b0;
    i_dbus_ack = 1'b0; i_dbus_err = 1'b0; i_dbus_rdata = '0;
    drive_nop();
    #12;
    // reset state
    chk("rst_stall", o_stall, 0);        chk("rst_req", o_dbus_req, 0);
    chk("rst_rd", o_rd, 0);              chk("rst_alu", o_alu_result, 0);
    chk("rst_pc", o_pc_p4, 0);           chk("rst_load_data", o_load_data, 0);
    chk("rst_reg_write", o_reg_write, 0); chk("rst_fault", o_fault, 0);
    chk("rst_misaligned", o_misaligned, 0); chk("rst_we", o_dbus_we, 0);
    chk("rst_sel", o_dbus_sel, 0);       chk("rst_addr", o_dbus_addr, 0);
    chk("rst_wdata", o_dbus_wdata, 0);
    @(negedge clk); i_reset_n = 1'b1;
    @(posedge clk); #1;
    clear_stage(); e_stall = 1'b0; chk_on = 1'b1;

    // non-memory pass-through
    clr_cnt();
    run_op(mk(3'b000, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 5'd7), 0, 1'b0, 32'h0, -1);
    chk("add_stall", o_stall, 0);

    // SW 0x100, 2 wait states
    clr_cnt();
    run_op(mk(3'b010, 1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0), 2, 1'b0, 32'h0, -1);
    chk("sw_req_cycles", req_cnt, 3);    chk("sw_stall_cycles", stall_cnt, 3);
    chk("sw_addr", obs_addr, 30'h40);    chk("sw_sel", obs_sel, 4'b1111);
    chk("sw_we", obs_we, 1);             chk("sw_wdata", obs_wdata, 32'hDEAD_BEEF);

    // LB / LBU 0x103, zero wait
    clr_cnt();
    run_op(mk(3'b000, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 5'd3), 0, 1'b0, 32'h8011_2233, -1);
    chk("lb_data", o_load_data, 32'hFFFF_FF80);
    chk("lb_stall_cycles", stall_cnt, 1);
    run_op(mk(3'b100, 1'b1, 1'b0, 32'h0000_0103, 32'h0, 5'd4), 0, 1'b0, 32'h8011_2233, -1);
    chk("lbu_data", o_load_data, 32'h0000_0080);

    // SH 0x102
    run_op(mk(3'b001, 1'b0, 1'b1, 32'h0000_0102, 32'h0000_ABCD, 5'd0), 1, 1'b0, 32'h0, -1);
    chk("sh_sel", obs_sel, 4'b1100);     chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);

    // more lanes and extensions, back to back
    run_op(mk(3'b000, 1'b0, 1'b1, 32'h0000_0101, 32'h1111_225A, 5'd0), 0, 1'b0, 32'h0, -1);
    chk("sb_sel", obs_sel, 4'b0010);     chk("sb_wdata", obs_wdata, 32'h5A5A_5A5A);
    run_op(mk(3'b001, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd5), 1, 1'b0, 32'h8001_7FFF, -1);
    chk("lh_data", o_load_data, 32'hFFFF_8001);
    run_op(mk(3'b101, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd6), 0, 1'b0, 32'h8001_F00F, -1);
    chk("lhu_data", o_load_data, 32'h0000_F00F);
    run_op(mk(3'b010, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 5'd8), 2, 1'b0, 32'hCAFE_F00D, -1);
    run_op(mk(3'b011, 1'b1, 1'b0, 32'h0000_0108, 32'h0, 5'd9), 0, 1'b0, 32'h8765_4321, -1);
    chk("f3_011_data", o_load_data, 32'h8765_4321);
    run_op(mk(3'b110, 1'b1, 1'b0, 32'h0000_010C, 32'h0, 5'd10), 0, 1'b0, 32'h0BAD_CAFE, -1);
    run_op(mk(3'b100, 1'b1, 1'b0, 32'h0000_0101, 32'h0, 5'd11), 0, 1'b0, 32'h0000_9900, -1);

    // LW misaligned: no request
    clr_cnt();
    run_op(mk(3'b010, 1'b1, 1'b0, 32'h0000_0101, 32'h0, 5'd12), 0, 1'b0, 32'h0, -1);
    chk("mis_flag", o_misaligned, 1);    chk("mis_reg_write", o_reg_write, 0);
    chk("mis_stall", o_stall, 0);
    run_op(mk(3'b001, 1'b0, 1'b1, 32'h0000_0103, 32'h0, 5'd0), 0, 1'b0, 32'h0, -1);
    chk("mis_req_cycles", req_cnt, 0);

    // LW flushed in first REQ cycle, ack three cycles later
    clr_cnt();
    run_op(mk(3'b010, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 5'd13), 3, 1'b0, 32'h5555_AAAA, 0);
    chk("flush_reg_write", o_reg_write, 0);
    chk("flush_stall_cycles", stall_cnt, 4);
    run_op(mk(3'b000, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 5'd14), 0, 1'b0, 32'h0, -1);
    chk("resume_rd", o_rd, 14);

    // flush while idle clears the stage
    drive(mk(3'b000, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd15));
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; clear_stage(); drive_nop();

    // LH with bus error
    run_op(mk(3'b001, 1'b1, 1'b0, 32'h0000_0302, 32'h0, 5'd16), 1, 1'b1, 32'h1234_5678, -1);
    chk("err_fault", o_fault, 1);        chk("err_reg_write", o_reg_write, 0);
    idle(2);

    // reset in the middle of a transfer
    chk_on = 1'b0;
    drive(mk(3'b010, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd17));
    @(posedge clk); #1;
    drive_nop();
    chk("midrst_req_before", o_dbus_req, 1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("midrst_req", o_dbus_req, 0);    chk("midrst_stall", o_stall, 0);
    chk("midrst_rd", o_rd, 0);
    @(posedge clk); #2 i_reset_n = 1'b1;
    @(posedge clk); #1;
    clear_stage(); e_stall = 1'b0; chk_on = 1'b1;
    run_op(mk(3'b010, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd18), 1, 1'b0, 32'h0F0F_0F0F, -1);
    chk("post_rst_lw", o_load_data, 32'h0F0F_0F0F);
    idle(2);
    chk_on = 1'b0;

    chk("sb_leftover", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

endmodule

// File: doc/rv_lsu.md
RV_LSU -- requirements
Module: rv_lsu

Interface
REQ-001 SHALL have ports (clock and reset first):
- i_clk  in  1  sole clock, rising edge
- i_reset_n  in  1  reset, asynchronous, active-low
- i_flush  in  1  synchronous stage clear
- i_alu_result  in  32  effective address / ALU result from execute
- i_rs2_val  in  32  store data
- i_rd  in  5  destination register
- i_pc_p4  in  [31:2]  return address
- i_res_src  in  2  writeback select
- i_funct3  in  3  access size/sign
- i_reg_write, i_mem_read, i_mem_write  in  1 each  control
- o_stall  out  1  hold upstream stages
- o_rd  out  5;  o_pc_p4  out  [31:2];  o_res_src  out  2;  o_alu_result  out  32  registered pass-through
- o_reg_write  out  1  writeback enable, gated by exceptions
- o_load_data  out  32  extended load result
- o_misaligned  out  1  misaligned access flag
- o_fault  out  1  bus error flag
- o_dbus_req  out  1  bus request
- o_dbus_we  out  1  write strobe
- o_dbus_addr  out  [31:2]  word address
- o_dbus_sel  out  4  byte lanes
- o_dbus_wdata  out  32  write data
- i_dbus_ack  in  1  transfer complete
- i_dbus_err  in  1  error, valid with ack
- i_dbus_rdata  in  32  read data, valid with ack
REQ-002 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-003 Stage registers SHALL load all i_* fields on a rising edge when o_stall=0 and i_flush=0; hold when o_stall=1.
REQ-004 i_flush=1 SHALL clear the stage registers to zero at the edge, with priority over load.
REQ-005 FSM states: IDLE, REQ. IDLE->REQ when a loading edge captures i_mem_read|i_mem_write with aligned address. REQ->IDLE on the edge where i_dbus_ack=1.
REQ-006 o_stall SHALL equal (state==REQ), registered; no combinational path from i_dbus_ack.
REQ-007 In REQ, o_dbus_req=1 and bus outputs SHALL come from dedicated request registers captured at REQ entry, stable until ack; in IDLE, o_dbus_req=0.
REQ-008 Alignment: funct3[1:0]=01 requires addr[0]=0; funct3[1:0]=1x requires addr[1:0]=00; byte always aligned.
REQ-009 Misaligned access: no bus request; o_misaligned=1 while it sits in the stage; o_reg_write=0.
REQ-010 Store lanes: SB sel=0001<<addr[1:0], wdata = byte replicated x4; SH sel=0011<<addr[1:0] (addr[1] only), wdata = half replicated x2; SW sel=1111.
REQ-011 Loads: o_dbus_we=0, o_dbus_sel=1111; on ack rdata latched into r_rdata.
REQ-012 o_load_data: LB/LBU select byte addr[1:0], LH/LHU select half addr[1]; sign-extend for 000/001, zero-extend for 100/101; 010 full word; 011/110/111 SHALL behave as 010.
REQ-013 i_dbus_err with ack SHALL set o_fault=1 and force o_reg_write=0 while the access remains in the stage.
REQ-014 Load result latency: captured at edge E; req asserted E..ack edge A; o_load_data valid in cycle after A; minimum 2 cycles in stage (zero-wait ack).
REQ-015 i_flush during REQ: stage registers clear, FSM stays REQ with request registers unchanged until ack; returned data discarded; o_stall remains 1 until ack.
REQ-016 Non-memory instructions SHALL pass through in one cycle with o_stall=0.

Reset
REQ-017 On i_reset_n=0, immediately: state=IDLE, all stage/request registers, r_rdata, and all outputs = 0.
REQ-018 Reset asserted in REQ SHALL abort the transaction (o_dbus_req drops asynchronously).

Verification
REQ-019 SW addr 0x100, data 0xDEADBEEF, ack after 2 wait cycles -> req 3 cycles, addr[31:2]=0x40, sel=1111, we=1, o_stall high 3 cycles.
REQ-020 LB addr 0x103, rdata 0x80112233, zero-wait -> o_load_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-021 SH addr 0x102, rs2 0x0000ABCD -> sel=1100, wdata=0xABCDABCD.
REQ-022 LW addr 0x101 -> no req, o_misaligned=1, o_reg_write=0, o_stall=0.
REQ-023 LW with flush in 1st REQ cycle, ack 3 cycles later -> o_reg_write=0, stall held until ack, then pipeline resumes.
REQ-024 Reset mid-REQ -> o_dbus_req=0, o_stall=0 immediately; LH with i_dbus_err -> o_fault=1, o_reg_write=0.
